// File: rtl/rl_lj_run_ctrl_if.sv
// Bundle of run-control, pipeline, result-memory and readback signals for rl_lj_run_ctrl.
// The slave modport is the controller's view; the master modport is the surrounding system's view.
interface rl_lj_run_ctrl_if #(
    parameter int DATA_WIDTH         = 32,
    parameter int RESULTS_ADDR_WIDTH = 14
);
    logic                            run_req;
    logic                            pipe_rst;
    logic                            pipe_start;
    logic                            pipe_done;
    logic                            force_valid;
    logic [DATA_WIDTH-1:0]           force_x;
    logic [DATA_WIDTH-1:0]           force_y;
    logic [DATA_WIDTH-1:0]           force_z;
    logic [RESULTS_ADDR_WIDTH-1:0]   mem_addr;
    logic [3*DATA_WIDTH-1:0]         mem_wdata;
    logic                            mem_wren;
    logic                            mem_rden;
    logic [3*DATA_WIDTH-1:0]         mem_q;
    logic                            rd_req;
    logic [3*DATA_WIDTH-1:0]         rd_data;
    logic                            rd_valid;
    logic                            rd_ready;
    logic                            rd_last;
    logic [RESULTS_ADDR_WIDTH:0]     result_count;
    logic                            overflow;
    logic                            busy;
    logic [31:0]                     cycle_count;

    modport slave (
        input  run_req, pipe_done, force_valid, force_x, force_y, force_z,
               mem_q, rd_req, rd_ready,
        output pipe_rst, pipe_start, mem_addr, mem_wdata, mem_wren, mem_rden,
               rd_data, rd_valid, rd_last, result_count, overflow, busy, cycle_count
    );

    modport master (
        output run_req, pipe_done, force_valid, force_x, force_y, force_z,
               mem_q, rd_req, rd_ready,
        input  pipe_rst, pipe_start, mem_addr, mem_wdata, mem_wren, mem_rden,
               rd_data, rd_valid, rd_last, result_count, overflow, busy, cycle_count
    );
endinterface

// File: rtl/rl_lj_run_ctrl.sv
// Run controller for the LJ force pipeline: resets/starts the pipeline, stores force triples, then streams them back.
// Define RL_LJ_CYCLE_COUNT_EN to build the saturating START+RUN cycle counter; otherwise cycle_count is tied to 0.
module rl_lj_run_ctrl #(
    parameter int DATA_WIDTH         = 32,
    parameter int RESULTS_ADDR_WIDTH = 14,
    parameter int RESULTS_DATA_NUM   = 10000,
    parameter int PIPE_RST_CYCLES    = 4
) (
    input logic               clk,
    input logic               rst,
    rl_lj_run_ctrl_if.slave   bus
);
    localparam int AW     = RESULTS_ADDR_WIDTH;
    localparam int CNT_W  = RESULTS_ADDR_WIDTH + 1;
    localparam int PRST_W = $clog2(PIPE_RST_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CAPACITY  = CNT_W'(RESULTS_DATA_NUM);
    localparam logic [PRST_W-1:0] PRST_LAST = PRST_W'(PIPE_RST_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRST,
        START,
        RUN,
        DONE,
        READ_ISSUE,
        READ_HOLD
    } state_e;

    state_e                  state_q;
    logic [PRST_W-1:0]       prstCnt_q;
    logic [CNT_W-1:0]        resultCount_q;
    logic [CNT_W-1:0]        rdPtr_q;
    logic                    overflow_q;
    logic                    pipeRst_q;
    logic                    pipeStart_q;
    logic [AW-1:0]           memAddr_q;
    logic [3*DATA_WIDTH-1:0] memWdata_q;
    logic                    memWren_q;
    logic                    memRden_q;
    logic [3*DATA_WIDTH-1:0] rdData_q;
    logic                    holdFirst_q;
    logic                    rdLast_q;
    logic [CNT_W-1:0]        rdPtr_d;

    assign rdPtr_d = rdPtr_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            prstCnt_q     <= '0;
            resultCount_q <= '0;
            rdPtr_q       <= '0;
            overflow_q    <= 1'b0;
            pipeRst_q     <= 1'b0;
            pipeStart_q   <= 1'b0;
            memAddr_q     <= '0;
            memWdata_q    <= '0;
            memWren_q     <= 1'b0;
            memRden_q     <= 1'b0;
            rdData_q      <= '0;
            holdFirst_q   <= 1'b0;
            rdLast_q      <= 1'b0;
        end else begin
            memWren_q <= 1'b0;
            memRden_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.run_req) begin
                        state_q       <= PRST;
                        pipeRst_q     <= 1'b1;
                        prstCnt_q     <= '0;
                        resultCount_q <= '0;
                        overflow_q    <= 1'b0;
                    end else if (state_q == DONE && bus.rd_req && resultCount_q != '0) begin
                        state_q   <= READ_ISSUE;
                        rdPtr_q   <= '0;
                        memRden_q <= 1'b1;
                        memAddr_q <= '0;
                        rdLast_q  <= (resultCount_q == CNT_W'(1));
                    end
                end
                PRST: begin
                    if (prstCnt_q == PRST_LAST) begin
                        state_q     <= START;
                        pipeRst_q   <= 1'b0;
                        pipeStart_q <= 1'b1;
                    end else begin
                        prstCnt_q <= prstCnt_q + 1'b1;
                    end
                end
                START: begin
                    state_q <= RUN;
                end
                RUN: begin
                    // A triple arriving alongside pipe_done is still stored.
                    if (bus.force_valid) begin
                        if (resultCount_q < CAPACITY) begin
                            memWren_q     <= 1'b1;
                            memAddr_q     <= resultCount_q[AW-1:0];
                            memWdata_q    <= {bus.force_z, bus.force_y, bus.force_x};
                            resultCount_q <= resultCount_q + 1'b1;
                        end else begin
                            overflow_q <= 1'b1;
                        end
                    end
                    if (bus.pipe_done) begin
                        state_q     <= DONE;
                        pipeStart_q <= 1'b0;
                    end
                end
                READ_ISSUE: begin
                    state_q     <= READ_HOLD;
                    holdFirst_q <= 1'b1;
                end
                READ_HOLD: begin
                    // mem_q is only valid in the first hold cycle, so latch it for stalls.
                    holdFirst_q <= 1'b0;
                    if (holdFirst_q) begin
                        rdData_q <= bus.mem_q;
                    end
                    if (bus.rd_ready) begin
                        rdPtr_q <= rdPtr_d;
                        if (rdLast_q) begin
                            state_q <= DONE;
                        end else begin
                            state_q   <= READ_ISSUE;
                            memRden_q <= 1'b1;
                            memAddr_q <= rdPtr_d[AW-1:0];
                            rdLast_q  <= (rdPtr_d == resultCount_q - 1'b1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.pipe_rst     = pipeRst_q;
    assign bus.pipe_start   = pipeStart_q;
    assign bus.mem_addr     = memAddr_q;
    assign bus.mem_wdata    = memWdata_q;
    assign bus.mem_wren     = memWren_q;
    assign bus.mem_rden     = memRden_q;
    assign bus.rd_valid     = (state_q == READ_HOLD);
    assign bus.rd_data      = holdFirst_q ? bus.mem_q : rdData_q;
    assign bus.rd_last      = (state_q == READ_HOLD) && rdLast_q;
    assign bus.result_count = resultCount_q;
    assign bus.overflow     = overflow_q;
    assign bus.busy         = !(state_q == IDLE || state_q == DONE);

`ifdef RL_LJ_CYCLE_COUNT_EN
    logic [31:0] cycleCount_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycleCount_q <= '0;
        end else if ((state_q == IDLE || state_q == DONE) && bus.run_req) begin
            cycleCount_q <= '0;
        end else if ((state_q == START || state_q == RUN) && cycleCount_q != 32'hFFFF_FFFF) begin
            cycleCount_q <= cycleCount_q + 32'd1;
        end
    end

    assign bus.cycle_count = cycleCount_q;
`else
    assign bus.cycle_count = 32'd0;
`endif
endmodule

// File: tb/tb_rl_lj_run_ctrl.sv
// Self-checking bench for rl_lj_run_ctrl: randomized runs compared against a queue model of stored results.
// Instance A uses default capacity with a 1-cycle-latency memory model; instance B has capacity 4 for overflow.
module tb_rl_lj_run_ctrl;
    localparam int DW    = 32;
    localparam int AW    = 14;
    localparam int W3    = 3 * DW;
    localparam int CAP_A = 10000;
    localparam int CAP_B = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rl_lj_run_ctrl_if #(.DATA_WIDTH(DW), .RESULTS_ADDR_WIDTH(AW)) busA ();
    rl_lj_run_ctrl_if #(.DATA_WIDTH(DW), .RESULTS_ADDR_WIDTH(AW)) busB ();

    rl_lj_run_ctrl #(.DATA_WIDTH(DW), .RESULTS_ADDR_WIDTH(AW), .RESULTS_DATA_NUM(CAP_A),
                     .PIPE_RST_CYCLES(4)) dutA (.clk(clk), .rst(rst), .bus(busA));
    rl_lj_run_ctrl #(.DATA_WIDTH(DW), .RESULTS_ADDR_WIDTH(AW), .RESULTS_DATA_NUM(CAP_B),
                     .PIPE_RST_CYCLES(4)) dutB (.clk(clk), .rst(rst), .bus(busB));

    int checks   = 0;
    int failures = 0;

    logic [W3-1:0] memA [0:255];
    logic [AW-1:0] wAddrA[$];
    logic [W3-1:0] wDataA[$];
    logic [AW-1:0] wAddrB[$];
    logic [W3-1:0] wDataB[$];
    logic [W3-1:0] refA[$];
    logic [DW-1:0] fltTab [5];

    // Result memory for A plus write monitors for both instances.
    always @(posedge clk) begin
        if (busA.mem_wren) begin
            memA[busA.mem_addr[7:0]] <= busA.mem_wdata;
            wAddrA.push_back(busA.mem_addr);
            wDataA.push_back(busA.mem_wdata);
        end
        if (busA.mem_rden) busA.mem_q <= memA[busA.mem_addr[7:0]];
        if (busB.mem_wren) begin
            wAddrB.push_back(busB.mem_addr);
            wDataB.push_back(busB.mem_wdata);
        end
    end

    function automatic logic [31:0] expCycles(input int runLen);
`ifdef RL_LJ_CYCLE_COUNT_EN
        return 32'(runLen + 1);
`else
        return 32'(runLen * 0);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startRunA(output int prstLen);
        busA.run_req = 1'b1;
        tick();
        busA.run_req = 1'b0;
        prstLen = 0;
        while (busA.pipe_rst === 1'b1 && prstLen < 20) begin
            prstLen++;
            tick();
        end
    endtask

    // Drives START plus n RUN cycles (pipe_done on the last) and records what the memory should hold.
    task automatic runCyclesA(input int n, input int pct, input int nDirected);
        logic [DW-1:0] x, y, z;
        busA.force_valid = 1'b1;
        busA.force_x = 32'hDEAD_BEEF;
        busA.force_y = '0;
        busA.force_z = '0;
        tick();
        for (int i = 0; i < n; i++) begin
            x = (i < nDirected) ? fltTab[i % 5] : $urandom;
            y = $urandom;
            z = $urandom;
            busA.force_valid = (i < nDirected) || ($urandom_range(99) < pct);
            busA.force_x = x;
            busA.force_y = y;
            busA.force_z = z;
            busA.pipe_done = (i == n - 1);
            if (busA.force_valid && refA.size() < CAP_A) refA.push_back({z, y, x});
            tick();
        end
        busA.force_valid = 1'b0;
        busA.pipe_done = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic seen;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({busA.busy, busA.pipe_rst, busA.pipe_start, busA.mem_wren, busA.mem_rden,
             busA.rd_valid, busA.rd_last, busA.overflow} !== 8'b0)
            begin failures++; $display("[TB] FAIL reset_flags got=%b exp=0", {busA.busy, busA.pipe_rst,
                busA.pipe_start, busA.mem_wren, busA.mem_rden, busA.rd_valid, busA.rd_last, busA.overflow}); end
        checks++;
        if (busA.result_count !== '0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", busA.result_count); end
        checks++;
        if (busA.cycle_count !== '0) begin failures++; $display("[TB] FAIL reset_cycles got=%0d exp=0", busA.cycle_count); end
        checks++;
        if ({busA.mem_addr, busA.rd_data} !== '0) begin failures++; $display("[TB] FAIL reset_data got=%0h exp=0", {busA.mem_addr, busA.rd_data}); end
        checks++;
        if ({busB.busy, busB.overflow, busB.result_count} !== '0) begin failures++; $display("[TB] FAIL reset_b got=%0h exp=0", {busB.busy, busB.overflow, busB.result_count}); end
        rst = 1'b0;
        busA.rd_req = 1'b1;
        busA.force_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen = seen | busA.mem_rden | busA.mem_wren | busA.busy;
        end
        busA.rd_req = 1'b0;
        busA.force_valid = 1'b0;
        checks++;
        if (seen !== 1'b0) begin failures++; $display("[TB] FAIL idle_ignore got=%b exp=0", seen); end
    endtask

    task automatic test_overflow();
        logic [W3-1:0] refB[$];
        logic [DW-1:0] x, y, z;
        int n;
        logic expOvf = 1'b0;
        wAddrB.delete();
        wDataB.delete();
        busB.run_req = 1'b1;
        tick();
        busB.run_req = 1'b0;
        n = 0;
        while (busB.pipe_rst === 1'b1 && n < 20) begin n++; tick(); end
        tick();
        for (int i = 0; i < 7; i++) begin
            x = $urandom; y = $urandom; z = $urandom;
            busB.force_valid = (i < 6);
            busB.force_x = x; busB.force_y = y; busB.force_z = z;
            busB.pipe_done = (i == 6);
            if (busB.force_valid) begin
                if (refB.size() < CAP_B) refB.push_back({z, y, x});
                else expOvf = 1'b1;
            end
            tick();
        end
        busB.force_valid = 1'b0;
        busB.pipe_done = 1'b0;
        tick();
        checks++;
        if (wAddrB.size() !== refB.size()) begin failures++; $display("[TB] FAIL ovf_writes got=%0d exp=%0d", wAddrB.size(), refB.size()); end
        for (int i = 0; i < refB.size() && i < wAddrB.size(); i++) begin
            checks++;
            if (wAddrB[i] !== AW'(i) || wDataB[i] !== refB[i])
                begin failures++; $display("[TB] FAIL ovf_entry%0d got=%0h/%0h exp=%0h/%0h", i, wAddrB[i], wDataB[i], i, refB[i]); end
        end
        checks++;
        if (busB.result_count !== (AW+1)'(refB.size())) begin failures++; $display("[TB] FAIL ovf_count got=%0d exp=%0d", busB.result_count, refB.size()); end
        tick();
        tick();
        checks++;
        if (busB.overflow !== expOvf) begin failures++; $display("[TB] FAIL ovf_sticky got=%b exp=%b", busB.overflow, expOvf); end
        busB.run_req = 1'b1;
        tick();
        busB.run_req = 1'b0;
        checks++;
        if ({busB.overflow, busB.result_count} !== '0) begin failures++; $display("[TB] FAIL ovf_clear got=%0h exp=0", {busB.overflow, busB.result_count}); end
    endtask

    task automatic test_run_directed();
        int len;
        refA.delete(); wAddrA.delete(); wDataA.delete();
        busA.run_req = 1'b1;
        tick();
        busA.run_req = 1'b0;
        checks++;
        if ({busA.busy, busA.pipe_start} !== 2'b10) begin failures++; $display("[TB] FAIL prst_entry got=%b exp=10", {busA.busy, busA.pipe_start}); end
        len = 0;
        while (busA.pipe_rst === 1'b1 && len < 20) begin len++; tick(); end
        checks++;
        if (len !== 4) begin failures++; $display("[TB] FAIL prst_len got=%0d exp=4", len); end
        checks++;
        if ({busA.pipe_start, busA.busy} !== 2'b11) begin failures++; $display("[TB] FAIL start_rise got=%b exp=11", {busA.pipe_start, busA.busy}); end
        runCyclesA(6, 0, 5);
        checks++;
        if (wAddrA.size() !== refA.size()) begin failures++; $display("[TB] FAIL run_writes got=%0d exp=%0d", wAddrA.size(), refA.size()); end
        for (int i = 0; i < refA.size() && i < wAddrA.size(); i++) begin
            checks++;
            if (wAddrA[i] !== AW'(i) || wDataA[i] !== refA[i])
                begin failures++; $display("[TB] FAIL run_entry%0d got=%0h/%0h exp=%0h/%0h", i, wAddrA[i], wDataA[i], i, refA[i]); end
        end
        checks++;
        if (busA.result_count !== (AW+1)'(refA.size())) begin failures++; $display("[TB] FAIL run_count got=%0d exp=%0d", busA.result_count, refA.size()); end
        checks++;
        if ({busA.busy, busA.overflow, busA.pipe_start} !== 3'b0) begin failures++; $display("[TB] FAIL run_done got=%b exp=000", {busA.busy, busA.overflow, busA.pipe_start}); end
        checks++;
        if (busA.cycle_count !== expCycles(6)) begin failures++; $display("[TB] FAIL run_cycles got=%0d exp=%0d", busA.cycle_count, expCycles(6)); end
    endtask

    task automatic test_readback();
        int len, cnt;
        logic [W3-1:0] held;
        logic stable;
        refA.delete();
        startRunA(len);
        runCyclesA(4, 0, 3);
        busA.rd_req = 1'b1;
        tick();
        busA.rd_req = 1'b0;
        for (int e = 0; e < 3; e++) begin
            cnt = 0;
            while (busA.rd_valid !== 1'b1 && cnt < 8) begin cnt++; tick(); end
            checks++;
            if (busA.rd_valid !== 1'b1) begin failures++; $display("[TB] FAIL rd_timeout%0d got=%b exp=1", e, busA.rd_valid); end
            checks++;
            if (busA.rd_data !== refA[e]) begin failures++; $display("[TB] FAIL rd_data%0d got=%0h exp=%0h", e, busA.rd_data, refA[e]); end
            checks++;
            if (busA.rd_last !== (e == 2)) begin failures++; $display("[TB] FAIL rd_last%0d got=%b exp=%b", e, busA.rd_last, (e == 2)); end
            if (e == 1) begin
                held = busA.rd_data;
                stable = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    if (busA.rd_valid !== 1'b1 || busA.rd_data !== held) stable = 1'b0;
                end
                checks++;
                if (stable !== 1'b1) begin failures++; $display("[TB] FAIL rd_stall got=%0h exp=%0h", busA.rd_data, held); end
            end
            busA.rd_ready = 1'b1;
            tick();
            busA.rd_ready = 1'b0;
        end
        checks++;
        if ({busA.busy, busA.rd_valid} !== 2'b00) begin failures++; $display("[TB] FAIL rd_end got=%b exp=00", {busA.busy, busA.rd_valid}); end
    endtask

    task automatic test_back_to_back();
        int len, cyc, idx;
        refA.delete(); wAddrA.delete(); wDataA.delete();
        startRunA(len);
        runCyclesA(100, 50, 0);
        checks++;
        if (busA.result_count !== (AW+1)'(refA.size())) begin failures++; $display("[TB] FAIL b2b_count got=%0d exp=%0d", busA.result_count, refA.size()); end
        checks++;
        if (busA.cycle_count !== expCycles(100)) begin failures++; $display("[TB] FAIL b2b_cycles got=%0d exp=%0d", busA.cycle_count, expCycles(100)); end
        busA.rd_ready = 1'b1;
        busA.rd_req = 1'b1;
        tick();
        busA.rd_req = 1'b0;
        cyc = 0;
        idx = 0;
        while (busA.busy === 1'b1 && cyc < 1000) begin
            if (busA.rd_valid === 1'b1) begin
                checks++;
                if (idx >= refA.size() || busA.rd_data !== refA[idx] || busA.rd_last !== (idx == refA.size() - 1))
                    begin failures++; $display("[TB] FAIL b2b_entry%0d got=%0h last=%b", idx, busA.rd_data, busA.rd_last); end
                idx++;
            end
            tick();
            cyc++;
        end
        busA.rd_ready = 1'b0;
        checks++;
        if (idx !== refA.size()) begin failures++; $display("[TB] FAIL b2b_entries got=%0d exp=%0d", idx, refA.size()); end
        checks++;
        if (cyc !== 2 * refA.size()) begin failures++; $display("[TB] FAIL b2b_rate got=%0d exp=%0d", cyc, 2 * refA.size()); end
        busA.run_req = 1'b1;
        busA.rd_req = 1'b1;
        tick();
        busA.run_req = 1'b0;
        busA.rd_req = 1'b0;
        checks++;
        if ({busA.pipe_rst, busA.mem_rden, busA.busy} !== 3'b101) begin failures++; $display("[TB] FAIL run_priority got=%b exp=101", {busA.pipe_rst, busA.mem_rden, busA.busy}); end
    endtask

    task automatic test_reset_mid_run();
        int len;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busA.pipe_rst, busA.busy} !== 2'b00) begin failures++; $display("[TB] FAIL rst_prst got=%b exp=00", {busA.pipe_rst, busA.busy}); end
        wAddrA.delete(); wDataA.delete();
        startRunA(len);
        tick();
        for (int i = 0; i < 2; i++) begin
            busA.force_valid = 1'b1;
            busA.force_x = $urandom; busA.force_y = $urandom; busA.force_z = $urandom;
            tick();
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({busA.busy, busA.pipe_start, busA.mem_wren} !== 3'b000) begin failures++; $display("[TB] FAIL rst_run got=%b exp=000", {busA.busy, busA.pipe_start, busA.mem_wren}); end
        checks++;
        if (busA.result_count !== '0) begin failures++; $display("[TB] FAIL rst_count got=%0d exp=0", busA.result_count); end
        rst = 1'b0;
        busA.force_valid = 1'b0;
        tick();
        checks++;
        if (wAddrA.size() !== 2) begin failures++; $display("[TB] FAIL rst_writes got=%0d exp=2", wAddrA.size()); end
    endtask

    task automatic test_empty_readback();
        int len;
        startRunA(len);
        runCyclesA(3, 0, 0);
        checks++;
        if (busA.result_count !== '0) begin failures++; $display("[TB] FAIL empty_count got=%0d exp=0", busA.result_count); end
        busA.rd_req = 1'b1;
        tick();
        busA.rd_req = 1'b0;
        checks++;
        if ({busA.busy, busA.mem_rden} !== 2'b00) begin failures++; $display("[TB] FAIL empty_read got=%b exp=00", {busA.busy, busA.mem_rden}); end
        tick();
        checks++;
        if ({busA.busy, busA.rd_valid} !== 2'b00) begin failures++; $display("[TB] FAIL empty_stay got=%b exp=00", {busA.busy, busA.rd_valid}); end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        fltTab = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000};
        rst = 1'b1;
        busA.run_req = 1'b0; busA.pipe_done = 1'b0; busA.force_valid = 1'b0;
        busA.force_x = '0; busA.force_y = '0; busA.force_z = '0;
        busA.rd_req = 1'b0; busA.rd_ready = 1'b0; busA.mem_q = '0;
        busB.run_req = 1'b0; busB.pipe_done = 1'b0; busB.force_valid = 1'b0;
        busB.force_x = '0; busB.force_y = '0; busB.force_z = '0;
        busB.rd_req = 1'b0; busB.rd_ready = 1'b0; busB.mem_q = '0;
        test_reset();
        test_overflow();
        test_run_directed();
        test_readback();
        test_back_to_back();
        test_reset_mid_run();
        test_empty_readback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rl_lj_run_ctrl.md
RL_LJ_RUN_CTRL -- requirements
Module: rl_lj_run_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, force component width.
REQ-002 SHALL have parameter RESULTS_ADDR_WIDTH, default 14, result memory address width.
REQ-003 SHALL have parameter RESULTS_DATA_NUM, default 10000, result memory capacity in entries.
REQ-004 SHALL have parameter PIPE_RST_CYCLES, default 4, pipeline reset pulse length.
REQ-005 SHALL have ports, clock and reset first; one clock; reset is synchronous and active-high:
 clk  in  1  sole clock
 rst  in  1  synchronous active-high reset
 run_req  in  1  begin run (sampled in IDLE/DONE)
 pipe_rst  out  1  reset to LJ pipeline
 pipe_start  out  1  start level to LJ pipeline
 pipe_done  in  1  pipeline finished
 force_valid  in  1  force triple valid
 force_x/force_y/force_z  in  DATA_WIDTH each  force components
 mem_addr  out  RESULTS_ADDR_WIDTH  result memory address
 mem_wdata  out  3*DATA_WIDTH  {z,y,x}
 mem_wren  out  1  write enable
 mem_rden  out  1  read enable
 mem_q  in  3*DATA_WIDTH  read data, 1-cycle latency
 rd_req  in  1  begin readback (sampled in DONE)
 rd_data  out  3*DATA_WIDTH  readback entry
 rd_valid  out  1  rd_data valid
 rd_ready  in  1  consumer accepts
 rd_last  out  1  final entry flag, qualified by rd_valid
 result_count  out  RESULTS_ADDR_WIDTH+1  entries stored this run
 overflow  out  1  sticky: force dropped, memory full
 busy  out  1  state not IDLE/DONE
 cycle_count  out  32  run cycles (REQ-022 only)

Function
REQ-006 SHALL implement states IDLE, PRST, START, RUN, DONE, READ_ISSUE, READ_HOLD.
REQ-007 SHALL, in IDLE or DONE with run_req=1, go to PRST and clear result_count, overflow, write pointer, cycle_count.
REQ-008 SHALL drive pipe_rst=1 for exactly PIPE_RST_CYCLES cycles in PRST, then enter START.
REQ-009 SHALL hold pipe_start=1 in START (one cycle) and throughout RUN; 0 elsewhere.
REQ-010 SHALL, in RUN, on force_valid=1 with result_count<RESULTS_DATA_NUM, register mem_wren=1, mem_addr=result_count, mem_wdata={force_z,force_y,force_x} next cycle (latency 1), and increment result_count.
REQ-011 SHALL, on force_valid=1 with result_count==RESULTS_DATA_NUM, drop the triple, no write, set overflow=1 until next run or rst.
REQ-012 SHALL go RUN->DONE on pipe_done=1; force_valid in that same cycle SHALL still be captured.
REQ-013 SHALL ignore force_valid outside RUN, run_req outside IDLE/DONE, rd_req outside DONE.
REQ-014 SHALL, in DONE with rd_req=1 (run_req has priority if both high), set read pointer 0 and enter READ_ISSUE; if result_count==0 stay in DONE.
REQ-015 SHALL in READ_ISSUE assert mem_rden=1, mem_addr=read pointer for one cycle, then enter READ_HOLD.
REQ-016 SHALL in READ_HOLD capture mem_q into rd_data on first cycle and assert rd_valid; rd_data SHALL stay stable while rd_valid=1 and rd_ready=0.
REQ-017 SHALL assert rd_last=1 with rd_valid when read pointer==result_count-1.
REQ-018 SHALL, on rd_valid&rd_ready, deassert rd_valid, increment read pointer, and go READ_ISSUE, or DONE after last entry; throughput one entry per 2 cycles minimum.
REQ-019 SHALL keep mem_wren=0 and mem_rden=0 except as in REQ-010/REQ-015; never both high.

Reset
REQ-020 SHALL on rst=1 (any state, including mid-run/mid-read) enter IDLE next cycle with all outputs 0, counters and pointers 0, overflow 0.
REQ-021 SHALL give rst priority over all other inputs.

Configuration
REQ-022 SHALL, with RL_LJ_CYCLE_COUNT_EN defined, increment cycle_count each cycle in START or RUN, saturating at 32'hFFFFFFFF, holding value in DONE/READ; without it, cycle_count SHALL be constant 0 and no counter logic SHALL exist.

Verification
REQ-023 rst, run_req pulse -> pipe_rst high 4 cycles, pipe_start rises next cycle, busy=1.
REQ-024 RUN, 5 force_valid pulses (x=1.0,2.0,...) then pipe_done -> writes addr 0..4, result_count=5, DONE, busy=0, overflow=0.
REQ-025 RESULTS_DATA_NUM=4, 6 force_valid -> 4 writes, result_count=4, overflow=1, no write at addr 4.
REQ-026 DONE with 3 entries, rd_req, rd_ready low 3 cycles on entry 1 -> rd_data stable, entries 0,1,2 in order, rd_last on entry 2, then DONE.
REQ-027 rst asserted mid-RUN after 2 writes -> IDLE, result_count=0, pipe_start=0, mem_wren=0 next cycle.
REQ-028 RL_LJ_CYCLE_COUNT_EN defined, RUN lasting 100 cycles -> cycle_count=101 (START+RUN); undefined -> 0.
